// File: rtl/seg7_scan_decoder_if.sv
// Bus between a multiplexed active-low 7-segment driver and the scan decoder
// that reads it back; the decoder side also returns the recovered digits.
interface seg7_scan_decoder_if #(
   parameter int NUM_DIGITS = 4
);
   logic [6:0]              seg_n;
   logic [NUM_DIGITS-1:0]   dig_n;
   logic [4*NUM_DIGITS-1:0] value;
   logic [NUM_DIGITS-1:0]   digit_err;
   logic                    frame_valid;

   modport master (
      output seg_n, dig_n,
      input  value, digit_err, frame_valid
   );

   modport slave (
      input  seg_n, dig_n,
      output value, digit_err, frame_valid
   );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers hex nibbles from a multiplexed active-low 7-segment bus, accepting a
// pattern only once it has been stable long enough to rule out scan ghosts.
module seg7_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst,
   seg7_scan_decoder_if.slave bus
);
   localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

   logic [6:0]              r_seg;
   logic [NUM_DIGITS-1:0]   r_dig;
   logic [7:0]              cnt;
   logic                    armed;
   logic [NUM_DIGITS-1:0]   seen;
   logic [4*NUM_DIGITS-1:0] value;
   logic [NUM_DIGITS-1:0]   digit_err;
   logic                    frame_valid;

   logic                    same;
   logic                    one_sel;
   logic                    capture;
   logic [NUM_DIGITS-1:0]   sel;
   logic [NUM_DIGITS-1:0]   seen_next;
   logic [7:0]              zeros;
   logic [4:0]              dec;

   // {valid, nibble}; valid clear means the pattern is not a hex glyph
   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'h40:   decode = {1'b1, 4'h0};
         7'h79:   decode = {1'b1, 4'h1};
         7'h24:   decode = {1'b1, 4'h2};
         7'h30:   decode = {1'b1, 4'h3};
         7'h19:   decode = {1'b1, 4'h4};
         7'h12:   decode = {1'b1, 4'h5};
         7'h02:   decode = {1'b1, 4'h6};
         7'h78:   decode = {1'b1, 4'h7};
         7'h00:   decode = {1'b1, 4'h8};
         7'h18:   decode = {1'b1, 4'h9};
         7'h08:   decode = {1'b1, 4'hA};
         7'h03:   decode = {1'b1, 4'hB};
         7'h46:   decode = {1'b1, 4'hC};
         7'h21:   decode = {1'b1, 4'hD};
         7'h06:   decode = {1'b1, 4'hE};
         7'h0E:   decode = {1'b1, 4'hF};
         default: decode = 5'b0_0000;
      endcase
   endfunction

   always_comb begin
      zeros = 8'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!r_dig[i]) zeros = zeros + 8'd1;
      end
      sel       = ~r_dig;
      one_sel   = (zeros == 8'd1);
      same      = ({bus.seg_n, bus.dig_n} == {r_seg, r_dig});
      capture   = same && (cnt == LAST) && armed && one_sel;
      dec       = decode(r_seg);
      seen_next = seen | sel;
   end

   // Sample, stability count, capture and frame tracking all settle on one edge
   always_ff @(posedge clk) begin
      if (rst) begin
         r_seg       <= '0;
         r_dig       <= '0;
         cnt         <= '0;
         armed       <= 1'b1;
         seen        <= '0;
         value       <= '0;
         digit_err   <= '0;
         frame_valid <= 1'b0;
      end else begin
         r_seg       <= bus.seg_n;
         r_dig       <= bus.dig_n;
         frame_valid <= 1'b0;
         if (!same) begin
            cnt   <= '0;
            armed <= 1'b1;
         end else if (cnt != LAST) begin
            cnt <= cnt + 8'd1;
         end
         if (capture) begin
            armed <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (sel[i]) begin
                  if (dec[4]) value[4*i +: 4] <= dec[3:0];
                  digit_err[i] <= ~dec[4];
               end
            end
            if (&seen_next) begin
               frame_valid <= 1'b1;
               seen        <= '0;
            end else begin
               seen <= seen_next;
            end
         end
      end
   end

   assign bus.value       = value;
   assign bus.digit_err   = digit_err;
   assign bus.frame_valid = frame_valid;
endmodule
